// File: rtl/sensor_bitstream_decimator.sv
// Multi-channel comparator bitstream decimator: synchronises N_CH bits, counts ones per window, streams snapshots.
// Optional threshold alarm enabled by defining SENSOR_DECIM_THRESH_ALARM_EN.
module sensor_bitstream_decimator #(
  parameter int N_CH        = 4,
  parameter int WIN_LOG2    = 8,
  parameter int SYNC_STAGES = 2,
  localparam int CNT_W      = WIN_LOG2 + 1,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sample_en,
  input  logic [N_CH-1:0]  bit_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_data,
  output logic [CH_W-1:0]  out_ch,
  output logic             overrun,
  input  logic             clear_ovr
`ifdef SENSOR_DECIM_THRESH_ALARM_EN
  ,
  input  logic [CNT_W-1:0] thresh,
  output logic [N_CH-1:0]  alarm
`endif
);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  logic [N_CH-1:0]     r_sync [SYNC_STAGES];
  logic [N_CH-1:0]     w_sync_bit;
  logic [WIN_LOG2-1:0] r_win_cnt;
  logic [CNT_W-1:0]    r_acc  [N_CH];
  logic [CNT_W-1:0]    w_cand [N_CH];
  logic [CNT_W-1:0]    r_snap [N_CH];
  logic                w_sample;
  logic                w_win_end;
  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_load;
  logic                w_hs;
  logic                w_last_hs;
  logic [CH_W-1:0]     r_out_ch;
  logic                r_overrun;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= bit_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_sync_bit = r_sync[SYNC_STAGES-1];
  assign w_sample   = enable & sample_en;
  assign w_win_end  = w_sample & (r_win_cnt == '1);

  always_comb begin
    for (int i = 0; i < N_CH; i++) w_cand[i] = r_acc[i] + CNT_W'(w_sync_bit[i]);
  end

  // NOTE: accumulator and snapshot arrays are reset too, so out_data reads 0 and no stale count survives reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_cnt <= '0;
      for (int i = 0; i < N_CH; i++) r_acc[i] <= '0;
    end else if (!enable) begin
      r_win_cnt <= '0;
      for (int i = 0; i < N_CH; i++) r_acc[i] <= '0;
    end else if (sample_en) begin
      r_win_cnt <= r_win_cnt + 1'b1;
      for (int i = 0; i < N_CH; i++) r_acc[i] <= w_win_end ? '0 : w_cand[i];
    end
  end

  assign out_valid = (r_state == S_SEND);
  assign w_hs      = out_valid & out_ready;
  assign w_last_hs = w_hs & (r_out_ch == CH_W'(N_CH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win_end) begin
          w_state_nxt = S_SEND;
          w_load      = 1'b1;
        end
      end
      S_SEND: begin
        if (w_last_hs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_ch <= '0;
      for (int i = 0; i < N_CH; i++) r_snap[i] <= '0;
    end else begin
      if (w_load) begin
        r_out_ch <= '0;
        for (int i = 0; i < N_CH; i++) r_snap[i] <= w_cand[i];
      end else if (w_hs) begin
        r_out_ch <= w_last_hs ? '0 : r_out_ch + 1'b1;
      end
    end
  end

  // A window ending while SEND is active (even on the final handshake) is dropped, never reloaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_overrun <= 1'b0;
    else if (w_win_end && r_state == S_SEND) r_overrun <= 1'b1;
    else if (clear_ovr)                       r_overrun <= 1'b0;
  end

  assign out_ch   = r_out_ch;
  assign out_data = r_snap[r_out_ch];
  assign overrun  = r_overrun;

`ifdef SENSOR_DECIM_THRESH_ALARM_EN
  logic [N_CH-1:0] r_alarm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alarm <= '0;
    end else if (w_load) begin
      for (int i = 0; i < N_CH; i++) r_alarm[i] <= (w_cand[i] >= thresh);
    end
  end

  assign alarm = r_alarm;
`endif

endmodule

// File: tb/tb_sensor_bitstream_decimator.sv
// Self-checking bench for sensor_bitstream_decimator (N_CH=4, WIN_LOG2=4): vector table plus corner sequences.
module tb_sensor_bitstream_decimator;
  localparam int N_CH  = 4;
  localparam int CNT_W = 5;
  localparam int CH_W  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             sample_en;
  logic [N_CH-1:0]  bit_in;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_data;
  logic [CH_W-1:0]  out_ch;
  logic             overrun;
  logic             clear_ovr;
`ifdef SENSOR_DECIM_THRESH_ALARM_EN
  logic [CNT_W-1:0] thresh;
  logic [N_CH-1:0]  alarm;
`endif

  sensor_bitstream_decimator #(.N_CH(N_CH), .WIN_LOG2(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .sample_en (sample_en),
    .bit_in    (bit_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .overrun   (overrun),
    .clear_ovr (clear_ovr)
`ifdef SENSOR_DECIM_THRESH_ALARM_EN
    ,
    .thresh    (thresh),
    .alarm     (alarm)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] data;
  } word_t;

  typedef struct {
    string                      name;
    logic [N_CH-1:0]            bits;
    logic [N_CH-1:0][CNT_W-1:0] exp;
  } vec_t;

  word_t exp_q[$];
  word_t mon_w;
  vec_t  vecs[5];
  int    total = 0;
  int    bad   = 0;
  int    stale;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_window(input logic [N_CH-1:0][CNT_W-1:0] exp);
    for (int i = 0; i < N_CH; i++) exp_q.push_back({CH_W'(i), exp[i]});
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", out_valid, 0);
  endtask

  task automatic setup(input logic [N_CH-1:0] bits);
    enable    = 1'b0;
    sample_en = 1'b0;
    bit_in    = bits;
    repeat (4) tick();
  endtask

  // One back-to-back window of constant bits with ready held high.
  task automatic run_window(input vec_t v);
    out_ready = 1'b1;
    setup(v.bits);
    push_window(v.exp);
    enable    = 1'b1;
    sample_en = 1'b1;
    repeat (15) tick();
    check({v.name, "_valid_early"}, out_valid, 0);
    tick();
    check({v.name, "_valid_rise"}, out_valid, 1);
    enable    = 1'b0;
    sample_en = 1'b0;
    wait_drain();
  endtask

  // Scoreboard: each accepted word is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 1, 0);
      end else begin
        mon_w = exp_q.pop_front();
        check("word_ch", out_ch, mon_w.ch);
        check("word_data", out_data, mon_w.data);
      end
    end
  end

  initial begin
    vecs[0] = '{name: "b0101", bits: 4'b0101, exp: {5'd0,  5'd16, 5'd0,  5'd16}};
    vecs[1] = '{name: "b1111", bits: 4'b1111, exp: {5'd16, 5'd16, 5'd16, 5'd16}};
    vecs[2] = '{name: "b0000", bits: 4'b0000, exp: {5'd0,  5'd0,  5'd0,  5'd0}};
    vecs[3] = '{name: "b1010", bits: 4'b1010, exp: {5'd16, 5'd0,  5'd16, 5'd0}};
    vecs[4] = '{name: "b1001", bits: 4'b1001, exp: {5'd16, 5'd0,  5'd0,  5'd16}};

    rst       = 1'b1;
    enable    = 1'b0;
    sample_en = 1'b0;
    bit_in    = '0;
    out_ready = 1'b0;
    clear_ovr = 1'b0;
`ifdef SENSOR_DECIM_THRESH_ALARM_EN
    thresh    = '0;
`endif
    repeat (3) tick();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ch", out_ch, 0);
    check("rst_overrun", overrun, 0);
`ifdef SENSOR_DECIM_THRESH_ALARM_EN
    check("rst_alarm", alarm, 0);
`endif
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) run_window(vecs[v]);

    // Backpressure: word (0,16) held, window 2 dropped, window 3 (bits 1010) delivered next.
    out_ready = 1'b0;
    setup(4'b0101);
    push_window({5'd0, 5'd16, 5'd0, 5'd16});
    push_window({5'd16, 5'd0, 5'd16, 5'd0});
    enable    = 1'b1;
    sample_en = 1'b1;
    for (int c = 1; c <= 48; c++) begin
      tick();
      if (c >= 16 && c <= 40 && c % 8 == 0) begin
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_ch", out_ch, 0);
        check("bp_hold_data", out_data, 16);
      end
      if (c == 30) bit_in = 4'b1010;
      if (c == 31) check("bp_ovr_before", overrun, 0);
      if (c == 32) check("bp_ovr_set", overrun, 1);
      if (c == 40) out_ready = 1'b1;
      if (c == 47) check("bp_gap_idle", out_valid, 0);
      if (c == 48) check("bp_win3_valid", out_valid, 1);
    end
    enable    = 1'b0;
    sample_en = 1'b0;
    wait_drain();
    check("bp_ovr_sticky", overrun, 1);
    clear_ovr = 1'b1;
    tick();
    clear_ovr = 1'b0;
    check("bp_ovr_cleared", overrun, 0);

    // Window end coinciding with the final handshake: overrun, no reload; set beats clear.
    out_ready = 1'b0;
    setup(4'b0101);
    push_window({5'd0, 5'd16, 5'd0, 5'd16});
    enable    = 1'b1;
    sample_en = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 28) out_ready = 1'b1;
      if (c == 31) begin
        check("co_ovr_before", overrun, 0);
        clear_ovr = 1'b1;
      end
      if (c == 32) begin
        clear_ovr = 1'b0;
        check("co_set_wins", overrun, 1);
        check("co_no_reload", out_valid, 0);
      end
      if (c == 36) check("co_still_idle", out_valid, 0);
    end
    enable    = 1'b0;
    sample_en = 1'b0;
    wait_drain();
    clear_ovr = 1'b1;
    tick();
    clear_ovr = 1'b0;
    check("co_ovr_cleared", overrun, 0);

    // Sparse strobes every 3rd cycle with bit_in[0] toggling: ch0 counts 8 over 48 cycles.
    out_ready = 1'b1;
    setup(4'b0000);
    push_window({5'd0, 5'd0, 5'd0, 5'd8});
    enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      sample_en = 1'b1;
      bit_in[0] = ~bit_in[0];
      if (k == 15) check("sparse_valid_early", out_valid, 0);
      tick();
      if (k == 15) check("sparse_valid_rise", out_valid, 1);
      sample_en = 1'b0;
      tick();
      tick();
    end
    enable = 1'b0;
    wait_drain();

    // Partial window discarded: 10 samples of 1111, gap, then 16 fresh samples of 0011.
    setup(4'b1111);
    enable    = 1'b1;
    sample_en = 1'b1;
    repeat (10) tick();
    enable = 1'b0;
    bit_in = 4'b0011;
    repeat (5) tick();
    check("partial_no_word", out_valid, 0);
    push_window({5'd0, 5'd0, 5'd16, 5'd16});
    enable = 1'b1;
    repeat (15) tick();
    check("partial_valid_early", out_valid, 0);
    tick();
    check("partial_valid_rise", out_valid, 1);
    enable    = 1'b0;
    sample_en = 1'b0;
    wait_drain();

    // Reset mid-drain with out_ch=2 and overrun set.
    out_ready = 1'b0;
    setup(4'b0101);
    push_window({5'd0, 5'd16, 5'd0, 5'd16});
    enable    = 1'b1;
    sample_en = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      tick();
      if (c == 16) out_ready = 1'b1;
      if (c == 18) begin
        out_ready = 1'b0;
        check("rm_ch2", out_ch, 2);
        check("rm_valid", out_valid, 1);
      end
      if (c == 32) check("rm_ovr_set", overrun, 1);
    end
    #2;
    rst       = 1'b1;
    enable    = 1'b0;
    sample_en = 1'b0;
    #1;
    check("rm_valid_drop", out_valid, 0);
    check("rm_ovr_clear", overrun, 0);
    check("rm_ch_clear", out_ch, 0);
    exp_q.delete();
    repeat (2) tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    stale     = 0;
    repeat (40) begin
      tick();
      if (out_valid) stale = 1;
    end
    check("rm_no_stale", stale, 0);

`ifdef SENSOR_DECIM_THRESH_ALARM_EN
    thresh = 5'd9;
    run_window(vecs[0]);
    check("alarm_t9", alarm, 4'b0101);
    thresh = 5'd17;
    run_window(vecs[0]);
    check("alarm_t17", alarm, 4'b0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
